// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the serial configuration chain loader: chain geometry,
// FSM state encoding and the bit position of every field in the chain.
package cfg_chain_pkg;

  localparam int CHAIN_LEN = 38;
  localparam int CFG_W     = 37;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Stage 0 is the first stage after the serial input.
  localparam int DSR_15                = 0;
  localparam int DSR_14                = 1;
  localparam int DSR_13                = 2;
  localparam int DSR_12                = 3;
  localparam int DSR_11                = 4;
  localparam int DSR_10                = 5;
  localparam int DSR_9                 = 6;
  localparam int DSR_8                 = 7;
  localparam int DSR_7                 = 8;
  localparam int DSR_6                 = 9;
  localparam int DSR_5                 = 10;
  localparam int DSR_4                 = 11;
  localparam int DSR_3                 = 12;
  localparam int DSR_2                 = 13;
  localparam int DSR_1                 = 14;
  localparam int DSR_0                 = 15;
  localparam int SR_LATCH_MUX_SEL_2    = 16;
  localparam int SR_LATCH_MUX_SEL_1    = 17;
  localparam int SR_LATCH_MUX_SEL_0    = 18;
  localparam int PGA_GAIN_3            = 19;
  localparam int PGA_GAIN_2            = 20;
  localparam int PGA_GAIN_1            = 21;
  localparam int PGA_GAIN_0            = 22;
  localparam int OFFSET_DAC_7          = 23;
  localparam int OFFSET_DAC_6          = 24;
  localparam int OFFSET_DAC_5          = 25;
  localparam int OFFSET_DAC_4          = 26;
  localparam int OFFSET_DAC_3          = 27;
  localparam int OFFSET_DAC_2          = 28;
  localparam int OFFSET_DAC_1          = 29;
  localparam int OFFSET_DAC_0          = 30;
  localparam int BIAS_TRIM_2           = 31;
  localparam int BIAS_TRIM_1           = 32;
  localparam int BIAS_TRIM_0           = 33;
  localparam int TEST_MODE_EN          = 34;
  localparam int OUT_DRIVE_SEL         = 35;
  localparam int SAMPLE_CLOCK_POLARITY = 36;
  localparam int DUMMY_STAGE           = 37;

endpackage

// File: rtl/cfg_chain_phase_gen.sv
// Phase timer for the serial clock: pulses tick_o on the last clk cycle of
// every CLK_DIV-cycle phase while enabled, and restarts from zero when idle.
module cfg_chain_phase_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Shifts a configuration word MSB-first into an external serial chain, reads the
// previous chain contents back through the dummy stage and flags readback errors.
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int CHAIN_LEN = cfg_chain_pkg::CHAIN_LEN,
  parameter int CFG_W     = cfg_chain_pkg::CFG_W,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [CFG_W-1:0]     load_data,
  output logic                 sr_clk,
  output logic                 sr_data,
  input  logic                 sr_dout,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rb_data,
  output logic                 mismatch
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("cfg_chain_loader: CLK_DIV must be at least 1");
  end
  if (CHAIN_LEN != CFG_W + 1) begin : g_bad_len
    $error("cfg_chain_loader: CHAIN_LEN must be CFG_W + 1");
  end

  state_e               state_q;
  logic [5:0]           bit_cnt_q;
  logic                 sr_clk_q;
  logic                 sr_data_q;
  logic                 done_q;
  logic                 mismatch_q;
  logic                 shadow_valid_q;
  logic [CHAIN_LEN-1:0] rb_q;
  logic [CHAIN_LEN-1:0] sw_q;
  logic [CFG_W-1:0]     cur_q;
  logic [CFG_W-1:0]     shadow_q;
  logic                 accept;
  logic                 phase_en;
  logic                 tick;

  assign accept   = load_valid && (state_q == IDLE);
  assign phase_en = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);

  cfg_chain_phase_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_gen (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (phase_en),
    .tick_o(tick)
  );

  // The dummy bit is driven straight away at accept; sw_q holds the remaining bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      sr_clk_q       <= 1'b0;
      sr_data_q      <= 1'b0;
      done_q         <= 1'b0;
      mismatch_q     <= 1'b0;
      shadow_valid_q <= 1'b0;
      rb_q           <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= SHIFT_LO;
            bit_cnt_q <= '0;
            sr_data_q <= 1'b0;
            rb_q      <= '0;
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            state_q  <= SHIFT_HI;
            sr_clk_q <= 1'b1;
            rb_q     <= {rb_q[CHAIN_LEN-2:0], sr_dout};
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            sr_clk_q <= 1'b0;
            if (bit_cnt_q == 6'(CHAIN_LEN - 1)) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              mismatch_q <= shadow_valid_q && (rb_q[CFG_W-1:0] != shadow_q);
            end else begin
              state_q   <= SHIFT_LO;
              bit_cnt_q <= bit_cnt_q + 6'd1;
              sr_data_q <= sw_q[CHAIN_LEN-1];
            end
          end
        end
        DONE: begin
          state_q        <= IDLE;
          shadow_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sw_q  <= {load_data, 1'b0};
      cur_q <= load_data;
    end else if ((state_q == SHIFT_HI) && tick) begin
      sw_q <= sw_q << 1;
    end
    if (state_q == DONE) begin
      shadow_q <= cur_q;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign sr_clk     = sr_clk_q;
  assign sr_data    = sr_data_q;
  assign done       = done_q;
  assign mismatch   = mismatch_q;
  assign rb_data    = rb_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader with a 38-stage behavioural chain on sr_clk.
module tb_cfg_chain_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [36:0] load_data = '0;
  logic        sr_clk;
  logic        sr_data;
  logic        sr_dout;
  logic        busy;
  logic        done;
  logic [37:0] rb_data;
  logic        mismatch;

  int checks = 0;
  int failures = 0;

  logic [37:0] chain = '0;
  logic        flip20 = 1'b0;
  int          sr_edges = 0;

  localparam logic [36:0] WA = 37'h0_AAAA_5555;
  localparam logic [36:0] WB = 37'h1_FFFF_0000;
  localparam logic [36:0] WC = 37'h0_1234_5678;
  localparam logic [36:0] WD = 37'h1_5A5A_5A5A;
  localparam logic [36:0] WE = 37'h0_F0F0_F0F0;
  localparam logic [36:0] WF = 37'h1_2345_6789;
  localparam logic [36:0] WG = 37'h0_0F0F_3C3C;

  always #5 clk = ~clk;

  cfg_chain_loader #(
    .CHAIN_LEN(38),
    .CFG_W    (37),
    .CLK_DIV  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .sr_clk    (sr_clk),
    .sr_data   (sr_data),
    .sr_dout   (sr_dout),
    .busy      (busy),
    .done      (done),
    .rb_data   (rb_data),
    .mismatch  (mismatch)
  );

  // Behavioural chain: stage 0 captures sr_data, stage 37 is the dummy output stage.
  always @(posedge sr_clk or posedge flip20) begin
    if (flip20) chain[20] <= ~chain[20];
    else        chain <= {chain[36:0], sr_data};
  end

  always @(posedge sr_clk) sr_edges <= sr_edges + 1;

  assign sr_dout = chain[37];

  // Drives one load and reports what was observed; comparisons live in the tests.
  task automatic run_load(input logic [36:0] w, input bit hold, output int lat,
                          output int edges, output bit ready_lo, output bit ready_after,
                          output bit done_after, output logic [37:0] rb, output bit mm);
    int e0;
    @(negedge clk);
    load_data  = w;
    load_valid = 1'b1;
    e0 = sr_edges;
    @(posedge clk);
    lat = -1;
    ready_lo = 1'b1;
    rb = '0;
    mm = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!hold) load_valid = 1'b0;
      if (load_ready) ready_lo = 1'b0;
      if (done) begin
        lat = n;
        rb  = rb_data;
        mm  = mismatch;
        break;
      end
    end
    load_valid = 1'b0;
    @(negedge clk);
    ready_after = load_ready;
    done_after  = done;
    edges = sr_edges - e0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (sr_clk !== 1'b0) begin failures++; $display("FAIL reset_sr_clk got=%b exp=0", sr_clk); end
    checks++; if (sr_data !== 1'b0) begin failures++; $display("FAIL reset_sr_data got=%b exp=0", sr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%b exp=0", mismatch); end
    checks++; if (rb_data !== 38'h0) begin failures++; $display("FAIL reset_rb_data got=%h exp=0", rb_data); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
  endtask

  task automatic test_first_load();
    int lat, edges; bit rlo, rafter, dafter, mm; logic [37:0] rb;
    run_load(WA, 1'b0, lat, edges, rlo, rafter, dafter, rb, mm);
    checks++; if (lat != 152) begin failures++; $display("FAIL first_latency got=%0d exp=152", lat); end
    checks++; if (edges != 38) begin failures++; $display("FAIL first_sr_edges got=%0d exp=38", edges); end
    checks++; if (chain[36:0] !== WA) begin failures++; $display("FAIL first_chain got=%h exp=%h", chain[36:0], WA); end
    checks++; if (chain[37] !== 1'b0) begin failures++; $display("FAIL first_dummy got=%b exp=0", chain[37]); end
    checks++; if (rb !== 38'h0) begin failures++; $display("FAIL first_rb got=%h exp=0", rb); end
    checks++; if (mm !== 1'b0) begin failures++; $display("FAIL first_mismatch got=%b exp=0", mm); end
    checks++; if (rlo !== 1'b1) begin failures++; $display("FAIL first_ready_low got=%b exp=1", rlo); end
    checks++; if (rafter !== 1'b1) begin failures++; $display("FAIL first_ready_after got=%b exp=1", rafter); end
    checks++; if (dafter !== 1'b0) begin failures++; $display("FAIL first_done_pulse got=%b exp=0", dafter); end
  endtask

  task automatic test_readback();
    int lat, edges; bit rlo, rafter, dafter, mm; logic [37:0] rb;
    run_load(WB, 1'b0, lat, edges, rlo, rafter, dafter, rb, mm);
    checks++; if (rb[36:0] !== WA) begin failures++; $display("FAIL rb_word got=%h exp=%h", rb[36:0], WA); end
    checks++; if (rb[37] !== 1'b0) begin failures++; $display("FAIL rb_dummy got=%b exp=0", rb[37]); end
    checks++; if (mm !== 1'b0) begin failures++; $display("FAIL rb_mismatch got=%b exp=0", mm); end
    checks++; if (chain[36:0] !== WB) begin failures++; $display("FAIL rb_chain got=%h exp=%h", chain[36:0], WB); end
  endtask

  task automatic test_mismatch();
    int lat, edges; bit rlo, rafter, dafter, mm; logic [37:0] rb;
    logic [36:0] exp_rb;
    exp_rb = WB ^ (37'h1 << 20);
    @(negedge clk);
    flip20 = 1'b1;
    #1 flip20 = 1'b0;
    run_load(WC, 1'b0, lat, edges, rlo, rafter, dafter, rb, mm);
    checks++; if (mm !== 1'b1) begin failures++; $display("FAIL mm_flag got=%b exp=1", mm); end
    checks++; if (rb[36:0] !== exp_rb) begin failures++; $display("FAIL mm_rb got=%h exp=%h", rb[36:0], exp_rb); end
    checks++; if ((rb[36:0] ^ WB) !== (37'h1 << 20)) begin failures++; $display("FAIL mm_diff got=%h exp=%h", rb[36:0] ^ WB, 37'h1 << 20); end
    repeat (3) @(negedge clk);
    checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL mm_hold got=%b exp=1", mismatch); end
    checks++; if (rb_data[36:0] !== exp_rb) begin failures++; $display("FAIL mm_rb_hold got=%h exp=%h", rb_data[36:0], exp_rb); end
  endtask

  task automatic test_back_to_back();
    int lat, edges, e1; bit rlo, rafter, dafter, mm; logic [37:0] rb;
    run_load(WD, 1'b1, lat, edges, rlo, rafter, dafter, rb, mm);
    e1 = sr_edges;
    checks++; if (lat != 152) begin failures++; $display("FAIL hold_latency got=%0d exp=152", lat); end
    checks++; if (edges != 38) begin failures++; $display("FAIL hold_sr_edges got=%0d exp=38", edges); end
    checks++; if (rlo !== 1'b1) begin failures++; $display("FAIL hold_ready_low got=%b exp=1", rlo); end
    checks++; if (rafter !== 1'b1) begin failures++; $display("FAIL hold_ready_after got=%b exp=1", rafter); end
    checks++; if (rb !== {1'b0, WC}) begin failures++; $display("FAIL hold_rb got=%h exp=%h", rb, {1'b0, WC}); end
    checks++; if (mm !== 1'b0) begin failures++; $display("FAIL hold_mismatch got=%b exp=0", mm); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_no_reaccept got=%b exp=0", busy); end
    checks++; if (sr_edges != e1) begin failures++; $display("FAIL hold_extra_edges got=%0d exp=%0d", sr_edges, e1); end
  endtask

  task automatic test_reset_abort();
    int lat, edges, e0; bit rlo, rafter, dafter, mm, hit; logic [37:0] rb;
    @(negedge clk);
    load_data  = WE;
    load_valid = 1'b1;
    e0 = sr_edges;
    @(negedge clk);
    load_valid = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if ((sr_edges - e0) == 10 && sr_clk) begin hit = 1'b1; break; end
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL abort_edge10 got=%0d exp=10", sr_edges - e0); end
    reset = 1'b0;
    #1;
    checks++; if (sr_clk !== 1'b0) begin failures++; $display("FAIL abort_sr_clk got=%b exp=0", sr_clk); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", load_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_load(WF, 1'b0, lat, edges, rlo, rafter, dafter, rb, mm);
    checks++; if (mm !== 1'b0) begin failures++; $display("FAIL abort_mismatch got=%b exp=0", mm); end
    checks++; if (edges != 38) begin failures++; $display("FAIL abort_sr_edges got=%0d exp=38", edges); end
    run_load(WG, 1'b0, lat, edges, rlo, rafter, dafter, rb, mm);
    checks++; if (rb !== {1'b0, WF}) begin failures++; $display("FAIL after_abort_rb got=%h exp=%h", rb, {1'b0, WF}); end
    checks++; if (mm !== 1'b0) begin failures++; $display("FAIL after_abort_mismatch got=%b exp=0", mm); end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_readback();
    test_mismatch();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 Parameters, one per line (name, default, meaning); CLK_DIV is checked at elaboration.
- CHAIN_LEN, 38, total serial stages: 37 config bits plus one dummy output stage.
- CFG_W, 37, config word width.
- CLK_DIV, 2, clk cycles per sr_clk phase; minimum 1.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, asynchronous, active-low reset.
- load_valid, in, 1, config word offered.
- load_ready, out, 1, loader can accept a word.
- load_data, in, CFG_W, config word; bit k lands in chain stage k (stage 0 = first stage after serial input, DSR_15).
- sr_clk, out, 1, serial chain clock; the chain captures on the rising edge.
- sr_data, out, 1, serial data into the chain.
- sr_dout, in, 1, serial data returned from the chain's dummy stage.
- busy, out, 1, shift in progress.
- done, out, 1, one-cycle pulse at end of shift.
- rb_data, out, CHAIN_LEN, previous chain contents captured during the shift.
- mismatch, out, 1, readback disagrees with the last written word; valid with done.

Function
REQ-003 A word is accepted when load_valid && load_ready; load_ready = (state == IDLE).
REQ-004 States are IDLE, SHIFT_LO, SHIFT_HI and DONE.
- IDLE -> SHIFT_LO on accept.
- SHIFT_LO -> SHIFT_HI after CLK_DIV cycles.
- SHIFT_HI -> SHIFT_LO after CLK_DIV cycles if bit_cnt < CHAIN_LEN-1, else -> DONE.
- DONE -> IDLE after 1 cycle.
REQ-005 The shift word is {1'b0, load_data}, registered at accept, and shifted MSB first: the dummy 0 goes first, load_data[0] goes last.
REQ-006 sr_data changes only on entry to SHIFT_LO, so it is stable for the full low and high phases.
REQ-007 sr_clk is a registered output: high exactly in SHIFT_HI, low in all other states.
REQ-008 bit_cnt (6 bits) clears at accept and increments on each SHIFT_HI -> SHIFT_LO transition; exactly CHAIN_LEN rising edges occur per load.
REQ-009 sr_dout is sampled in the last SHIFT_LO cycle of each bit and shifted into rb_data from the LSB side. After 38 samples, rb_data[k] equals the pre-load content of stage k (rb_data[37] = dummy stage).
REQ-010 Latency: with accept at cycle T, DONE (done=1) occurs at T+1+2*CLK_DIV*CHAIN_LEN, and load_ready is high again at the following cycle.
REQ-011 A shadow register holds the last fully shifted load_data and sets shadow_valid. It is updated in DONE, after the compare.
REQ-012 In DONE, mismatch = shadow_valid && (rb_data[CFG_W-1:0] != shadow). mismatch holds until the next DONE; rb_data holds until the next accept.
REQ-013 busy = (state != IDLE). load_valid asserted while busy is ignored and never queued.
REQ-014 Back-to-back loads: a word presented during DONE waits; the earliest re-accept is the IDLE cycle immediately after DONE.

Reset
REQ-015 On reset low, asynchronously:
- state = IDLE, sr_clk = 0, sr_data = 0, busy = 0, done = 0, mismatch = 0.
- rb_data = 0, bit_cnt = 0, shadow_valid = 0.
REQ-016 Reset during a shift aborts it. Chain contents are then undefined and the next load's mismatch shall be 0 (shadow invalid).

Structure
REQ-017 Package cfg_chain_pkg holds:
- CHAIN_LEN and CFG_W.
- the state enum.
- named bit-index constants for every chain field (DSR_15..DSR_0 at 0..15, SR_LATCH_MUX_SEL_2..0 at 16..18, through SAMPLE_CLOCK_POLARITY at 36).
REQ-018 One sub-module, cfg_chain_phase_gen, generates the CLK_DIV phase-end tick. Everything else stays in cfg_chain_loader.

Verification (bench includes a 38-stage behavioural chain clocked by sr_clk)
REQ-019 Reset: hold reset low 5 cycles -> all outputs at REQ-015 values; load_ready=1 after release.
REQ-020 CLK_DIV=2, load 37'h0_AAAA_5555 accepted at T -> 38 sr_clk rising edges, done at T+153, and model stages 0..36 equal the word.
REQ-021 Second load 37'h1_FFFF_0000 -> rb_data[36:0] = 37'h0_AAAA_5555, rb_data[37] = 0, mismatch = 0.
REQ-022 Force model stage 20 inverted between loads -> next done has mismatch = 1, with rb_data bit 20 the only differing bit.
REQ-023 load_valid held high throughout a shift -> only one accept, load_ready=0 until DONE+1, and no extra sr_clk edges.
REQ-024 Reset asserted at the 10th rising edge -> sr_clk=0 and state IDLE immediately; the next full load gives mismatch = 0.
